// File: rtl/sp_ram_pkg.sv
// Shared constants and FSM state type for the parametrised single-port RAM.
package sp_ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } sp_ram_state_t;

endpackage

// File: rtl/param_sp_ram_if.sv
// Request/response bundle for param_sp_ram; req_mask exists only with SP_RAM_BYTE_EN.
interface param_sp_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
`ifdef SP_RAM_BYTE_EN
  logic [DATA_W/8-1:0] req_mask;
`endif
  logic              resp_valid;
  logic [DATA_W-1:0] q;
  logic              busy;

`ifdef SP_RAM_BYTE_EN
  modport master (output req_valid, req_we, req_addr, req_data, req_mask,
                  input  req_ready, resp_valid, q, busy);
  modport slave  (input  req_valid, req_we, req_addr, req_data, req_mask,
                  output req_ready, resp_valid, q, busy);
`else
  modport master (output req_valid, req_we, req_addr, req_data,
                  input  req_ready, resp_valid, q, busy);
  modport slave  (input  req_valid, req_we, req_addr, req_data,
                  output req_ready, resp_valid, q, busy);
`endif
endinterface

// File: rtl/sp_ram_array.sv
// Raw storage: one synchronous write port, combinational read; byte enables with SP_RAM_BYTE_EN.
module sp_ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef SP_RAM_BYTE_EN
  input  logic [DATA_W/8-1:0] be,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
`ifdef SP_RAM_BYTE_EN
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
`else
      mem[addr] <= wdata;
`endif
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/param_sp_ram.sv
// Single-port RAM with clear-after-reset, 1-cycle registered response and RDW policy select.
// Optional byte-masked writes are enabled by defining SP_RAM_BYTE_EN.
//
// state    | meaning
// ST_CLEAR | zeroing mem[ptr] each cycle; requests ignored
// ST_READY | accepting requests until the next reset
module param_sp_ram
  import sp_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic clk,
  input  logic reset,
  param_sp_ram_if.slave io
);

  sp_ram_state_t     state;
  logic [ADDR_W-1:0] ptr;
  logic              clearing;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] q_r;
  logic              resp_r;

  assign clearing = (state == ST_CLEAR);
  assign accept   = io.req_valid & (state == ST_READY);

  // Reset wins over a coincident accept: nothing is written on a reset edge.
  assign mem_we    = ~reset & (clearing | (accept & io.req_we));
  assign mem_addr  = clearing ? ptr : io.req_addr;
  assign mem_wdata = clearing ? '0  : io.req_data;

`ifdef SP_RAM_BYTE_EN
  logic [DATA_W/8-1:0] mem_be;
  assign mem_be = clearing ? '1 : io.req_mask;

  always_comb begin
    merged = rdata;
    for (int i = 0; i < DATA_W/8; i++) begin
      if (io.req_mask[i]) merged[8*i +: 8] = io.req_data[8*i +: 8];
    end
  end
`else
  assign merged = io.req_data;
`endif

  sp_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
`ifdef SP_RAM_BYTE_EN
    .be    (mem_be),
`endif
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_CLEAR;
      ptr    <= '0;
      resp_r <= 1'b0;
      q_r    <= '0;
    end else begin
      resp_r <= 1'b0;
      case (state)
        ST_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == '1) state <= ST_READY;
        end
        ST_READY: begin
          if (accept) begin
            resp_r <= 1'b1;
            q_r    <= (RDW_MODE == RDW_WRITE_FIRST && io.req_we) ? merged : rdata;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  assign io.req_ready  = (state == ST_READY);
  assign io.busy       = (state == ST_CLEAR);
  assign io.resp_valid = resp_r;
  assign io.q          = q_r;

endmodule

// File: tb/tb_param_sp_ram.sv
// Bench for param_sp_ram: read-first and write-first instances driven in lockstep against a reference model.
module tb_param_sp_ram;

`ifdef SP_RAM_BYTE_EN
  localparam int DW = 16;
`else
  localparam int DW = 8;
`endif
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  param_sp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  param_sp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  param_sp_ram #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .io    (bus0.slave)
  );
  param_sp_ram #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .io    (bus1.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: memory contents and expected outputs after each edge
  logic [DW-1:0] m_mem [DEPTH];
  int            m_since;
  bit            m_ready;
  bit            m_rv;
  logic [DW-1:0] m_q0, m_q1;
`ifdef SP_RAM_BYTE_EN
  logic [DW/8-1:0] mask_drv = '1;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic r);
    logic [DW-1:0] old_w, new_w;
    reset          = r;
    bus0.req_valid = v;  bus1.req_valid = v;
    bus0.req_we    = we; bus1.req_we    = we;
    bus0.req_addr  = a;  bus1.req_addr  = a;
    bus0.req_data  = d;  bus1.req_data  = d;
`ifdef SP_RAM_BYTE_EN
    bus0.req_mask  = mask_drv; bus1.req_mask = mask_drv;
`endif
    @(posedge clk);
    if (r) begin
      m_ready = 0; m_since = 0; m_rv = 0; m_q0 = '0; m_q1 = '0;
    end else if (!m_ready) begin
      m_rv = 0;
      m_since++;
      if (m_since == DEPTH) begin
        m_ready = 1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else begin
      m_rv = v;
      if (v) begin
        old_w = m_mem[a];
        new_w = d;
`ifdef SP_RAM_BYTE_EN
        for (int b = 0; b < DW/8; b++)
          if (!mask_drv[b]) new_w[8*b +: 8] = old_w[8*b +: 8];
`endif
        if (we) m_mem[a] = new_w;
        m_q0 = old_w;
        m_q1 = we ? new_w : old_w;
      end
    end
    #1;
    chk("resp_valid_rf", {31'd0, bus0.resp_valid}, {31'd0, m_rv});
    chk("resp_valid_wf", {31'd0, bus1.resp_valid}, {31'd0, m_rv});
    chk("q_rf", 32'(bus0.q), 32'(m_q0));
    chk("q_wf", 32'(bus1.q), 32'(m_q1));
    chk("req_ready", {31'd0, bus0.req_ready}, {31'd0, m_ready});
    chk("busy", {31'd0, bus1.busy}, {31'd0, !m_ready});
  endtask

  // Runs idle or ignored-request cycles until ready; returns the number of edges taken.
  task automatic wait_ready(input logic v, input logic we, input logic [DW-1:0] d, output int n);
    n = 0;
    while (!bus0.req_ready && n < 4 * DEPTH) begin
      step(v, we, '0, d, 1'b0);
      n++;
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_q0;
    logic [DW-1:0] exp_q1;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{1'b0, 6'd0,  DW'('h00), DW'('h00), DW'('h00)};
    tbl[1] = '{1'b1, 6'd3,  DW'('hA5), DW'('h00), DW'('hA5)};
    tbl[2] = '{1'b0, 6'd3,  DW'('h00), DW'('hA5), DW'('hA5)};
    tbl[3] = '{1'b1, 6'd10, DW'('h11), DW'('h00), DW'('h11)};
    tbl[4] = '{1'b1, 6'd10, DW'('h22), DW'('h11), DW'('h22)};
    tbl[5] = '{1'b0, 6'd10, DW'('h00), DW'('h22), DW'('h22)};
    tbl[6] = '{1'b1, 6'd63, DW'('hFF), DW'('h00), DW'('hFF)};
    tbl[7] = '{1'b0, 6'd63, DW'('h00), DW'('hFF), DW'('hFF)};
    tbl[8] = '{1'b0, 6'd0,  DW'('h00), DW'('h00), DW'('h00)};
    tbl[9] = '{1'b0, 6'd3,  DW'('h00), DW'('hA5), DW'('hA5)};

    m_ready = 0; m_since = 0; m_rv = 0; m_q0 = '0; m_q1 = '0;
    reset = 1'b1;
    bus0.req_valid = 0; bus1.req_valid = 0;
    bus0.req_we = 0;    bus1.req_we = 0;
    bus0.req_addr = '0; bus1.req_addr = '0;
    bus0.req_data = '0; bus1.req_data = '0;
`ifdef SP_RAM_BYTE_EN
    bus0.req_mask = '1; bus1.req_mask = '1;
`endif
    step(0, 0, '0, '0, 1'b1);
    step(0, 0, '0, '0, 1'b1);

    // clear with a write to address 0 held on the request port the whole time
    wait_ready(1'b1, 1'b1, DW'('hFF), n);
    chk("clear_cycles", 32'(n), 32'(DEPTH));

    for (int i = 0; i < 10; i++) begin
      step(1, tbl[i].we, tbl[i].addr, tbl[i].data, 1'b0);
      chk("tbl_q_rf", 32'(bus0.q), 32'(tbl[i].exp_q0));
      chk("tbl_q_wf", 32'(bus1.q), 32'(tbl[i].exp_q1));
    end
    step(0, 0, '0, '0, 1'b0);
    chk("pulse_end", {31'd0, bus0.resp_valid}, 32'd0);

`ifdef SP_RAM_BYTE_EN
    mask_drv = 2'b11; step(1, 1, 6'd5, 16'hBEEF, 1'b0);
    mask_drv = 2'b01; step(1, 1, 6'd5, 16'h1234, 1'b0);
    chk("mask_wf", 32'(bus1.q), 32'h0000BE34);
    mask_drv = 2'b00; step(1, 1, 6'd5, 16'hFFFF, 1'b0);
    mask_drv = 2'b11; step(1, 0, 6'd5, 16'h0000, 1'b0);
    chk("mask_read", 32'(bus0.q), 32'h0000BE34);
`endif

    // reset coinciding with accepts in READY, then reset again mid-clear
    step(1, 0, 6'd3, '0, 1'b0);
    step(1, 1, 6'd3, DW'('h5A), 1'b1);
    chk("reset_abort", {31'd0, bus0.resp_valid}, 32'd0);
    for (int i = 0; i < 30; i++) step(0, 0, '0, '0, 1'b0);
    step(0, 0, '0, '0, 1'b1);
    wait_ready(1'b0, 1'b0, '0, n);
    chk("reclear_cycles", 32'(n), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, AW'(i), '0, 1'b0);
      chk("clear_zero", 32'(bus0.q), 32'd0);
    end

    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
`ifdef SP_RAM_BYTE_EN
      mask_drv = (DW/8)'($urandom);
`endif
      step(($urandom_range(0, 3) != 0), 1'($urandom), a, DW'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
